// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the instruction fetch front end.
//   fstate_e      - fetch FSM states (BOOT, RUN, HALT)
//   fetch_entry_t - one fetch-buffer entry {pc, instr}
//   RESET_PC_DEF  - default PC after reset
//   NOP           - canonical RISC-V nop (addi x0,x0,0)
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fstate_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch buffer between fetch and decode.
//   clk, reset    - clock, async active-high reset
//   push, wdata   - enqueue one entry (dropped if full and no pop)
//   pop           - dequeue head (ignored when empty)
//   flush         - drop all entries; overrides push/pop
//   head          - head entry, all-zero when empty
//   count, full   - occupancy
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rptr, wptr;
  logic            empty, pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty && !flush;
  // A pop in the same cycle frees a slot, so a full buffer may still accept.
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, fetch FSM and fetch buffer feeding decode.
//   clk, reset                  - clock, async active-high reset
//   imem_addr / imem_instr      - combinational instruction memory port
//   redirect_valid/redirect_pc  - branch/jump/trap redirect (highest priority)
//   halt                        - level request to stop fetching
//   if_valid/if_ready/if_pc/if_instr - buffer head handshake to decode
//   halted                      - HALT state with empty buffer
// Optional: FETCH_MISALIGN_CHK_EN adds output misalign, a one-cycle pulse
// after a redirect whose target is not word aligned; the target's low two
// bits are cleared.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  fstate_e                    state, state_nxt;
  logic [31:0]                pc, pc_nxt, tgt;
  logic                       push, pop, flush, full;
  logic [$clog2(BUF_DEPTH):0] count;
  fetch_entry_t               head;

  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;
  assign halted    = (state == HALT) && (count == '0);

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  assign tgt = redirect_pc;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // next state; a redirect never changes HALT while halt is held
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt && !redirect_valid) state_nxt = HALT;
      HALT:    if (!halt) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // outputs: redirect > halt > push/pop
  always_comb begin
    flush  = redirect_valid;
    pop    = if_valid && if_ready && !redirect_valid;
    push   = (state == RUN) && !redirect_valid && !halt && (!full || pop);
    pc_nxt = pc;
    if (redirect_valid) pc_nxt = tgt;
    else if (push)      pc_nxt = pc + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_nxt;
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ('{pc: pc, instr: imem_instr}),
    .head  (head),
    .count (count),
    .full  (full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        halted;
  logic        use_pat;
  int          total = 0;
  int          bad   = 0;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  // memory: all-NOP, or an address-derived pattern so instr/pc pairing is visible
  always_comb imem_instr = use_pat ? (imem_addr ^ PAT) : NOP;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign       (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    halt = 1'b0; if_ready = 1'b1; use_pat = 1'b0;
    #2;
    // reset values
    chk("rst_valid",  {31'b0, if_valid}, 32'd0);
    chk("rst_pc",     if_pc,             32'd0);
    chk("rst_instr",  if_instr,          32'd0);
    chk("rst_halted", {31'b0, halted},   32'd0);
    chk("rst_addr",   imem_addr,         32'd0);

    // streaming NOPs: BOOT one cycle, then 0,4,8,12
    do_reset();
    tick();
    chk("boot_valid", {31'b0, if_valid}, 32'd0);
    chk("boot_addr",  imem_addr,         32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("run_valid", {31'b0, if_valid}, 32'd1);
      chk("run_pc",    if_pc,             32'(4 * k));
      chk("run_instr", if_instr,          NOP);
    end

    // mid-operation async reset discards buffer
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, if_valid}, 32'd0);
    chk("async_addr",  imem_addr,         32'd0);

    // backpressure: 2 entries held, pc stalls at 8
    if_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("bp_valid", {31'b0, if_valid}, 32'd1);
    chk("bp_head",  if_pc,             32'd0);
    chk("bp_addr",  imem_addr,         32'd8);
    if_ready = 1'b1;
    tick(); chk("bp_pc4",  if_pc, 32'd4);
    tick(); chk("bp_pc8",  if_pc, 32'd8);
    tick(); chk("bp_pc12", if_pc, 32'd12);

    // redirect with full buffer
    if_ready = 1'b0;
    tick(); tick();
    chk("full_addr", imem_addr, 32'd20);
    use_pat = 1'b1;
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_addr",  imem_addr,         32'h100);
    tick();
    chk("redir_pc0",    if_pc,    32'h100);
    chk("redir_instr0", if_instr, 32'h100 ^ PAT);
    tick();
    chk("redir_pc1",    if_pc,    32'h104);
    chk("redir_instr1", if_instr, 32'h104 ^ PAT);

    // halt: fill to 2, halt, drain, resume at held pc
    if_ready = 1'b0;
    tick(); tick();
    halt = 1'b1;
    tick();
    chk("halt_full_halted", {31'b0, halted}, 32'd0);
    chk("halt_full_head",   if_pc,           32'h104);
    chk("halt_full_addr",   imem_addr,       32'h10C);
    if_ready = 1'b1;
    tick();
    chk("halt_drain_head", if_pc, 32'h108);
    chk("halt_drain_halted", {31'b0, halted}, 32'd0);
    tick();
    chk("halt_empty_valid",  {31'b0, if_valid}, 32'd0);
    chk("halt_empty_halted", {31'b0, halted},   32'd1);
    tick();
    chk("halt_hold_halted", {31'b0, halted}, 32'd1);
    chk("halt_hold_addr",   imem_addr,       32'h10C);
    halt = 1'b0;
    tick();
    chk("resume_halted", {31'b0, halted},   32'd0);
    chk("resume_valid",  {31'b0, if_valid}, 32'd0);
    tick();
    chk("resume_pc",    if_pc,    32'h10C);
    chk("resume_instr", if_instr, 32'h10C ^ PAT);

    // redirect while halted keeps HALT
    halt = 1'b1;
    tick();
    chk("h2_halted", {31'b0, halted}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("hredir_addr",   imem_addr,       32'h200);
    chk("hredir_halted", {31'b0, halted}, 32'd1);
    halt = 1'b0;
    tick(); tick();
    chk("hredir_pc", if_pc, 32'h200);

    // wrap at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_valid", {31'b0, if_valid}, 32'd0);
    tick(); chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
    tick(); chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
    tick(); chk("wrap_pc2", if_pc, 32'h0000_0000);
    chk("wrap_instr2", if_instr, PAT);

`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_idle", {31'b0, misalign}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_addr",  imem_addr,         32'h100);
    tick();
    chk("mis_clear", {31'b0, misalign}, 32'd0);
    chk("mis_pc",    if_pc,             32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
